// File: rtl/pitch_pkg.sv
// Shared widths, saturation limits and sample types for the pitch error path.
package pitch_pkg;
  localparam int PTCH_W  = 16;
  localparam int ERR_W   = 10;
  localparam int DDIFF_W = 6;
  localparam int INTEG_W = 18;

  localparam int ERR_MAX   = 511;
  localparam int ERR_MIN   = -512;
  localparam int DDIFF_MAX = 31;
  localparam int DDIFF_MIN = -32;
  localparam int INTEG_MAX = 131071;
  localparam int INTEG_MIN = -131072;

  typedef logic signed [PTCH_W-1:0] ptch_t;
  typedef logic signed [ERR_W-1:0]  err_t;
endpackage

// File: rtl/sat_signed.sv
// Generic two's-complement saturator: narrows IN_W bits to OUT_W bits, clipping to the
// most negative / most positive representable output value.
module sat_signed #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 10
) (
  input  logic signed [IN_W-1:0]  in_i,
  output logic signed [OUT_W-1:0] out_o
);
  // The value fits when every bit above the output sign bit matches that sign bit.
  logic [IN_W-OUT_W:0] top_bits;

  always_comb begin
    top_bits = in_i[IN_W-1:OUT_W-1];
    if ((&top_bits) || !(|top_bits)) begin
      out_o = in_i[OUT_W-1:0];
    end else if (in_i[IN_W-1]) begin
      out_o = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      out_o = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
endmodule

// File: rtl/ptch_err_proc.sv
// Pitch error conditioning: saturated error, derivative against a circular history queue,
// and (with macro PTCH_INTEG_EN defined) a saturating integrator output ptch_integ.
module ptch_err_proc
  import pitch_pkg::*;
#(
  parameter int D_QUEUE_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  ptch_t                     ptch,
  input  logic                      vld,
  input  logic                      clr,
  output err_t                      ptch_err_sat,
  output logic signed [DDIFF_W-1:0] ptch_D_diff,
  output logic                      out_vld,
`ifdef PTCH_INTEG_EN
  output logic signed [INTEG_W-1:0] ptch_integ,
`endif
  output logic                      q_full
);
  // vld is a one-cycle strobe with no back-pressure: each sample accepted (vld & !clr)
  // yields exactly one out_vld pulse on the following edge; clr wins over vld.
  localparam int PTR_W  = (D_QUEUE_DEPTH > 1) ? $clog2(D_QUEUE_DEPTH) : 1;
  localparam int FILL_W = $clog2(D_QUEUE_DEPTH + 1);

  err_t                      q_mem_q [D_QUEUE_DEPTH];
  err_t                      q_mem_d [D_QUEUE_DEPTH];
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0]         fill_q, fill_d;
  err_t                      err_q, err_d;
  logic signed [DDIFF_W-1:0] ddiff_q, ddiff_d;
  logic                      out_vld_q, out_vld_d;
  err_t                      sat_new, oldest;
  logic signed [ERR_W:0]     diff_raw;
  logic signed [DDIFF_W-1:0] diff_sat;

  sat_signed #(.IN_W(PTCH_W), .OUT_W(ERR_W)) u_sat_err (.in_i(ptch), .out_o(sat_new));

  // One extra bit makes the difference of two 10-bit values exact.
  assign oldest   = q_mem_q[rd_ptr_q];
  assign diff_raw = {sat_new[ERR_W-1], sat_new} - {oldest[ERR_W-1], oldest};

  sat_signed #(.IN_W(ERR_W+1), .OUT_W(DDIFF_W)) u_sat_diff (.in_i(diff_raw), .out_o(diff_sat));

  always_comb begin
    q_mem_d   = q_mem_q;
    rd_ptr_d  = rd_ptr_q;
    fill_d    = fill_q;
    err_d     = err_q;
    ddiff_d   = ddiff_q;
    out_vld_d = 1'b0;
    if (clr) begin
      for (int i = 0; i < D_QUEUE_DEPTH; i++) q_mem_d[i] = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end else if (vld) begin
      q_mem_d[rd_ptr_q] = sat_new;
      rd_ptr_d  = (rd_ptr_q == PTR_W'(D_QUEUE_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      if (fill_q != FILL_W'(D_QUEUE_DEPTH)) fill_d = fill_q + 1'b1;
      err_d     = sat_new;
      ddiff_d   = diff_sat;
      out_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < D_QUEUE_DEPTH; i++) q_mem_q[i] <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      err_q     <= '0;
      ddiff_q   <= '0;
      out_vld_q <= 1'b0;
    end else begin
      q_mem_q   <= q_mem_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      err_q     <= err_d;
      ddiff_q   <= ddiff_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign ptch_err_sat = err_q;
  assign ptch_D_diff  = ddiff_q;
  assign out_vld      = out_vld_q;
  assign q_full       = (fill_q == FILL_W'(D_QUEUE_DEPTH));

`ifdef PTCH_INTEG_EN
  logic signed [INTEG_W-1:0] integ_q, integ_d, integ_sat;
  logic signed [INTEG_W:0]   integ_sum;

  assign integ_sum = {integ_q[INTEG_W-1], integ_q}
                   + {{(INTEG_W+1-ERR_W){sat_new[ERR_W-1]}}, sat_new};

  sat_signed #(.IN_W(INTEG_W+1), .OUT_W(INTEG_W)) u_sat_integ (.in_i(integ_sum), .out_o(integ_sat));

  always_comb begin
    integ_d = integ_q;
    if (clr)      integ_d = '0;
    else if (vld) integ_d = integ_sat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) integ_q <= '0;
    else     integ_q <= integ_d;
  end

  assign ptch_integ = integ_q;
`endif
endmodule

// File: tb/tb_ptch_err_proc.sv
// Directed bench for ptch_err_proc (D_QUEUE_DEPTH=4); integrator checks compile in with PTCH_INTEG_EN.
module tb_ptch_err_proc;
  logic               clk;
  logic               rst;
  logic signed [15:0] ptch;
  logic               vld;
  logic               clr;
  logic signed [9:0]  ptch_err_sat;
  logic signed [5:0]  ptch_D_diff;
  logic               out_vld;
  logic               q_full;
`ifdef PTCH_INTEG_EN
  logic signed [17:0] ptch_integ;
`endif

  int n_vec;
  int n_err;

  ptch_err_proc #(.D_QUEUE_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .ptch         (ptch),
    .vld          (vld),
    .clr          (clr),
    .ptch_err_sat (ptch_err_sat),
    .ptch_D_diff  (ptch_D_diff),
    .out_vld      (out_vld),
`ifdef PTCH_INTEG_EN
    .ptch_integ   (ptch_integ),
`endif
    .q_full       (q_full)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drivers: inputs change on the falling edge, outputs are sampled 1 ns after the rising edge.
  task automatic apply(input int p, input logic v, input logic c);
    @(negedge clk);
    ptch = 16'(p);
    vld  = v;
    clr  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    vld = 1'b0;
    clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++; if (ptch_err_sat !== 10'sd0) begin n_err++; $display("FAIL reset_sat got %0d want 0", ptch_err_sat); end
    n_vec++; if (ptch_D_diff !== 6'sd0) begin n_err++; $display("FAIL reset_diff got %0d want 0", ptch_D_diff); end
    n_vec++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL reset_out_vld got %b want 0", out_vld); end
    n_vec++; if (q_full !== 1'b0) begin n_err++; $display("FAIL reset_q_full got %b want 0", q_full); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_pos_sat();
    apply(1000, 1'b1, 1'b0);
    n_vec++; if (ptch_err_sat !== 10'sd511) begin n_err++; $display("FAIL pos_sat got %0d want 511", ptch_err_sat); end
    n_vec++; if (ptch_D_diff !== 6'sd31) begin n_err++; $display("FAIL pos_diff got %0d want 31", ptch_D_diff); end
    n_vec++; if (out_vld !== 1'b1) begin n_err++; $display("FAIL pos_out_vld got %b want 1", out_vld); end
    apply(-300, 1'b0, 1'b0);
    n_vec++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL idle_out_vld got %b want 0", out_vld); end
    n_vec++; if (ptch_err_sat !== 10'sd511) begin n_err++; $display("FAIL idle_hold_sat got %0d want 511", ptch_err_sat); end
    n_vec++; if (ptch_D_diff !== 6'sd31) begin n_err++; $display("FAIL idle_hold_diff got %0d want 31", ptch_D_diff); end
  endtask

  task automatic test_neg_sat();
    do_reset();
    apply(-2000, 1'b1, 1'b0);
    n_vec++; if (ptch_err_sat !== -10'sd512) begin n_err++; $display("FAIL neg_sat got %0d want -512", ptch_err_sat); end
    n_vec++; if (ptch_D_diff !== -6'sd32) begin n_err++; $display("FAIL neg_diff got %0d want -32", ptch_D_diff); end
    apply(0, 1'b0, 1'b0);
  endtask

  // 10..50 from empty: raw diffs 10,20,30,40,40 clip to 31 above the derivative range.
  task automatic test_fill();
    int   samp  [5] = '{10, 20, 30, 40, 50};
    int   ediff [5] = '{10, 20, 30, 31, 31};
    logic efull [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply(samp[i], 1'b1, 1'b0);
      n_vec++; if (ptch_err_sat !== 10'(samp[i])) begin n_err++; $display("FAIL fill_sat[%0d] got %0d want %0d", i, ptch_err_sat, samp[i]); end
      n_vec++; if (ptch_D_diff !== 6'(ediff[i])) begin n_err++; $display("FAIL fill_diff[%0d] got %0d want %0d", i, ptch_D_diff, ediff[i]); end
      n_vec++; if (q_full !== efull[i]) begin n_err++; $display("FAIL fill_q_full[%0d] got %b want %b", i, q_full, efull[i]); end
    end
    apply(0, 1'b0, 1'b0);
  endtask

  // Ramp 0,5,...,55 back to back: diff is i*5 until the queue is full, then 20 across every wrap.
  task automatic test_back_to_back();
    int exp_diff;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      apply(i * 5, 1'b1, 1'b0);
      exp_diff = (i < 4) ? i * 5 : 20;
      n_vec++; if (out_vld !== 1'b1) begin n_err++; $display("FAIL b2b_out_vld[%0d] got %b want 1", i, out_vld); end
      n_vec++; if (ptch_D_diff !== 6'(exp_diff)) begin n_err++; $display("FAIL b2b_diff[%0d] got %0d want %0d", i, ptch_D_diff, exp_diff); end
      n_vec++; if (q_full !== (i >= 3)) begin n_err++; $display("FAIL b2b_q_full[%0d] got %b want %b", i, q_full, (i >= 3)); end
    end
  endtask

  // Follows the ramp: outputs last held 55 / 20.
  task automatic test_clr();
    apply(100, 1'b1, 1'b1);
    n_vec++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL clr_out_vld got %b want 0", out_vld); end
    n_vec++; if (ptch_err_sat !== 10'sd55) begin n_err++; $display("FAIL clr_hold_sat got %0d want 55", ptch_err_sat); end
    n_vec++; if (ptch_D_diff !== 6'sd20) begin n_err++; $display("FAIL clr_hold_diff got %0d want 20", ptch_D_diff); end
    n_vec++; if (q_full !== 1'b0) begin n_err++; $display("FAIL clr_q_full got %b want 0", q_full); end
    apply(8, 1'b1, 1'b0);
    n_vec++; if (ptch_D_diff !== 6'sd8) begin n_err++; $display("FAIL clr_next_diff got %0d want 8", ptch_D_diff); end
    n_vec++; if (ptch_err_sat !== 10'sd8) begin n_err++; $display("FAIL clr_next_sat got %0d want 8", ptch_err_sat); end
    n_vec++; if (out_vld !== 1'b1) begin n_err++; $display("FAIL clr_next_out_vld got %b want 1", out_vld); end
    apply(0, 1'b0, 1'b0);
  endtask

  task automatic test_async_rst();
    do_reset();
    for (int i = 0; i < 6; i++) apply(200 + i, 1'b1, 1'b0);
    // Raise rst between edges while vld is still high.
    @(negedge clk);
    ptch = 16'sd300;
    #1 rst = 1'b1;
    #1;
    n_vec++; if (ptch_err_sat !== 10'sd0) begin n_err++; $display("FAIL arst_sat got %0d want 0", ptch_err_sat); end
    n_vec++; if (ptch_D_diff !== 6'sd0) begin n_err++; $display("FAIL arst_diff got %0d want 0", ptch_D_diff); end
    n_vec++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL arst_out_vld got %b want 0", out_vld); end
    n_vec++; if (q_full !== 1'b0) begin n_err++; $display("FAIL arst_q_full got %b want 0", q_full); end
`ifdef PTCH_INTEG_EN
    n_vec++; if (ptch_integ !== 18'sd0) begin n_err++; $display("FAIL arst_integ got %0d want 0", ptch_integ); end
`endif
    vld = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    // Queue emptied: first sample after reset differences against zero.
    apply(9, 1'b1, 1'b0);
    n_vec++; if (ptch_D_diff !== 6'sd9) begin n_err++; $display("FAIL arst_first_diff got %0d want 9", ptch_D_diff); end
    n_vec++; if (q_full !== 1'b0) begin n_err++; $display("FAIL arst_first_q_full got %b want 0", q_full); end
    apply(0, 1'b0, 1'b0);
  endtask

`ifdef PTCH_INTEG_EN
  task automatic test_integ();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      apply(511, 1'b1, 1'b0);
      if (i == 9) begin
        n_vec++; if (ptch_integ !== 18'sd5110) begin n_err++; $display("FAIL integ_10 got %0d want 5110", ptch_integ); end
      end
    end
    n_vec++; if (ptch_integ !== 18'sd131071) begin n_err++; $display("FAIL integ_sat got %0d want 131071", ptch_integ); end
    apply(-2000, 1'b1, 1'b0);
    n_vec++; if (ptch_integ !== 18'sd130559) begin n_err++; $display("FAIL integ_neg got %0d want 130559", ptch_integ); end
    apply(0, 1'b0, 1'b1);
    n_vec++; if (ptch_integ !== 18'sd0) begin n_err++; $display("FAIL integ_clr got %0d want 0", ptch_integ); end
    for (int i = 0; i < 5; i++) apply(100, 1'b1, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++; if (ptch_integ !== 18'sd0) begin n_err++; $display("FAIL integ_arst got %0d want 0", ptch_integ); end
    n_vec++; if (ptch_err_sat !== 10'sd0) begin n_err++; $display("FAIL integ_arst_sat got %0d want 0", ptch_err_sat); end
    vld = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask
`endif

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;
    ptch  = '0;
    vld   = 1'b0;
    clr   = 1'b0;
    test_reset();
    test_pos_sat();
    test_neg_sat();
    test_fill();
    test_back_to_back();
    test_clr();
    test_async_rst();
`ifdef PTCH_INTEG_EN
    test_integ();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
